// File: rtl/byte_merge_fifo_if.sv
// Handshake bundle for byte_merge_fifo: two joined source streams, one drained output
// stream, and the occupancy count.
interface byte_merge_fifo_if #(
  parameter int unsigned CW = 3
);
  logic          cc_valid;
  logic [0:7]    cc;
  logic          cc_ready;
  logic          bb_valid;
  logic [0:7]    bb;
  logic          bb_ready;
  logic          aa_valid;
  logic [0:7]    aa;
  logic          aa_ready;
  logic [CW-1:0] count;

  modport master (
    output cc_valid, cc, bb_valid, bb, aa_ready,
    input  cc_ready, bb_ready, aa_valid, aa, count
  );

  modport slave (
    input  cc_valid, cc, bb_valid, bb, aa_ready,
    output cc_ready, bb_ready, aa_valid, aa, count
  );
endinterface

// File: rtl/byte_merge_fifo.sv
// Joins one cc beat and one bb beat into a single byte (fixed lane split) and buffers the
// merged bytes in a small register FIFO drained through a valid/ready output.
module byte_merge_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SPLIT = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  byte_merge_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [0:7]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic [0:7]    merged;

  // Lanes [0:SPLIT-1] from cc, the rest from bb; index 0 is the MSB.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      merged[i] = (i < SPLIT) ? bus.cc[i] : bus.bb[i];
    end
  end

  // Full comes from registered count only, so a same-cycle pop never frees a slot early.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cc_valid & bus.bb_valid & ~full;
  assign pop   = bus.aa_valid & bus.aa_ready;

  assign bus.cc_ready = bus.bb_valid & ~full;
  assign bus.bb_ready = bus.cc_valid & ~full;
  assign bus.aa_valid = ~empty;
  assign bus.aa       = empty ? 8'h00 : mem_q[rp_q];
  assign bus.count    = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= merged;
  end
endmodule

// File: doc/byte_merge_fifo.md
# byte_merge_fifo

Join-and-buffer stage that feeds the two-source byte register stage. It accepts two 8-bit source streams `cc` and `bb`, each with valid/ready. It merges one beat from each into a single byte with a fixed, non-overlapping lane split, so every merged bit has exactly one source. Merged bytes go into a small FIFO that the downstream stage drains through a valid/ready output.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `SPLIT`, 4: lane boundary, 1..7. Merged bits [0:SPLIT-1] come from `cc`; bits [SPLIT:7] come from `bb`.
- `CW`, $clog2(DEPTH+1): width of `count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cc_valid` in 1: `cc` beat offered.
- `cc` in [0:7]: source byte for the low-index lanes.
- `cc_ready` out 1: `cc` beat accepted this cycle.
- `bb_valid` in 1: `bb` beat offered.
- `bb` in [0:7]: source byte for the high-index lanes.
- `bb_ready` out 1: `bb` beat accepted this cycle.
- `aa_valid` out 1: head entry present.
- `aa` out [0:7]: head entry.
- `aa_ready` in 1: downstream takes the head.
- `count` out [CW-1:0]: current occupancy.

## Operation
- Bit order follows the port declaration [0:7]; index 0 is the MSB.
- Merge rule: `merged[i] = cc[i]` for i < SPLIT, else `bb[i]`. Each merged bit has exactly one driver; there are no overlapping lanes.
- Join rule:
  - `push = cc_valid & bb_valid & ~full`.
  - `cc_ready = bb_valid & ~full`.
  - `bb_ready = cc_valid & ~full`.
  - Both sources are consumed on the same edge or neither is. A lone valid source is held indefinitely and is never partially consumed.
- Pop rule: `pop = aa_valid & aa_ready`.
- `full = (count == DEPTH)`; `empty = (count == 0)`.
- `full` is computed from registered state only. A push is refused while full even if a pop occurs in the same cycle.
- Storage: DEPTH×8 register array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0 by natural overflow.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (possible only when not full and not empty): unchanged, both pointers advance.
- Output:
  - `aa_valid = ~empty`.
  - `aa = mem[rp]` when not empty, else 8'h00. The output is combinational from registers; there is no input-to-output combinational path.
- `aa` and `aa_valid` stay stable while `aa_valid & ~aa_ready`.
- Reset (async assert, any time, including mid-transfer):
  - `wp`, `rp` and `count` go to 0.
  - `aa_valid` = 0, `aa` = 8'h00.
  - `cc_ready` and `bb_ready` follow their combinational equations (not full), so they may be 1 during reset if the other valid is high.
  - No handshake completes while `rst_n` = 0.
  - Array contents are don't-care after reset.
- Each storage bit is written from exactly one always block; each output has a single driver.

## Timing
- Push sampled at rising edge N. `aa_valid` = 1 and `count` incremented are visible from edge N until the next edge, with minimum latency 1 cycle.
- Full throughput: with `aa_ready` held at 1 and both sources streaming, one byte per cycle in and out, and `count` steady at 1.
- At full: both readies drop in the same cycle `count` reaches DEPTH. They return in the cycle after the first pop.
- Reset release: synchronous usage begins at the first rising edge after `rst_n` rises. Deassertion is assumed to be synchronised externally.

## Test plan
- **Basic merge:** reset, `SPLIT`=4, `cc`=8'hF0, `bb`=8'h0F, both valid one cycle, `aa_ready`=0. Required: `count`=1, `aa_valid`=1, `aa`=8'hFF held. Repeat with `cc`=8'h0F, `bb`=8'hF0: `aa`=8'h00 appears after the first is popped.
- **Lone source:** `cc_valid`=1 with `bb_valid`=0 for 5 cycles. Required: `cc_ready`=0, `count`=0, `aa_valid`=0. Raising `bb_valid` pushes exactly one entry on the next edge.
- **Fill and drain:** push 4 distinct bytes (8'h11, 8'h22, 8'h33, 8'h44 via matching lanes) with `aa_ready`=0. Required: `count`=4, both readies 0, and a fifth offer is not consumed. Then `aa_ready`=1 drains 11, 22, 33, 44 in order with no gaps.
- **Simultaneous push/pop at count 2:** `count` unchanged, order preserved, pointers wrap correctly after 6 total pushes.
- **Reset mid-operation:** `count`=3, assert `rst_n`=0 between edges. Required: `aa_valid`=0, `aa`=8'h00, `count`=0 immediately, with no handshake completing while `rst_n`=0. After release, the first push reads back correctly.
- **SPLIT variants:** `SPLIT`=1 and `SPLIT`=7 with `cc`=8'hFF, `bb`=8'h00. Required: `aa`=8'h80 and 8'hFE respectively.
